// File: rtl/fft32_pkg.sv
// Shared types and constants for the 32-point FFT stage sequencer.
// Frame geometry, FSM encoding and a counter-width helper.
package fft32_pkg;

    localparam int FFT_N     = 32;
    localparam int FFT_LANES = 4;
    localparam int TW_W      = 9;
    localparam int FFT_NGRP  = FFT_N / FFT_LANES;

    typedef enum logic [2:0] {
        IDLE,
        START,
        ALIGN,
        RUN,
        DRAIN,
        DONE
    } fsm_state_t;

    // Width of a down-counter that must hold max(a,b); never narrower than 1 bit.
    function automatic int cnt_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m > 0) ? $clog2(m + 1) : 1;
    endfunction

endpackage

// File: rtl/fft32_delay_cnt.sv
// Loadable down-counter with a zero flag; load wins over decrement.
// Saturates at zero, so a stray decrement never wraps.
module fft32_delay_cnt #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/fft32_stage_ctrl.sv
// Frame sequencer: START/ALIGN/RUN per pass, then DRAIN and a held OUT_VLD.
// Frame spans 1 + NPASS*(1+W_LAT+NGRP*GCYC) + BF_LAT cycles; OUT_VLD holds until OUT_RDY.
module fft32_stage_ctrl
    import fft32_pkg::*;
#(
    parameter int NGRP   = FFT_NGRP,
    parameter int GCYC   = 4,
    parameter int NPASS  = 2,
    parameter int W_LAT  = 3,
    parameter int BF_LAT = 4
) (
    input  logic                                   CLK,
    input  logic                                   RST,
    input  logic                                   IN_VLD,
    output logic                                   IN_RDY,
    output logic                                   W_START,
    output logic                                   W_STAGE,
    output logic                                   BF_EN,
    output logic [((NGRP > 1) ? $clog2(NGRP) : 1)-1:0] GRP,
    output logic [((GCYC > 1) ? $clog2(GCYC) : 1)-1:0] PH,
    output logic                                   BANK,
    output logic                                   PASS_DONE,
    output logic                                   OUT_VLD,
    input  logic                                   OUT_RDY,
    output logic                                   BUSY
);

    localparam int GW = (NGRP > 1) ? $clog2(NGRP) : 1;
    localparam int PHW = (GCYC > 1) ? $clog2(GCYC) : 1;
    localparam int PW = (NPASS > 1) ? $clog2(NPASS) : 1;
    localparam int DW = cnt_width(W_LAT, BF_LAT);

    localparam logic [GW-1:0]  GRP_LAST  = GW'(NGRP - 1);
    localparam logic [PHW-1:0] PH_LAST   = PHW'(GCYC - 1);
    localparam logic [PW-1:0]  PASS_LAST = PW'(NPASS - 1);
    localparam logic [DW-1:0]  ALIGN_LD  = DW'((W_LAT > 0) ? W_LAT - 1 : 0);
    localparam logic [DW-1:0]  DRAIN_LD  = DW'((BF_LAT > 0) ? BF_LAT - 1 : 0);

    fsm_state_t state, state_d;

    logic [PW-1:0]  pass, pass_d;
    logic [GW-1:0]  grp_d;
    logic [PHW-1:0] ph_d;
    logic           bank_d;
    logic           cnt_load;
    logic [DW-1:0]  cnt_val;
    logic           cnt_dec;
    logic           cnt_zero;

    fft32_delay_cnt #(
        .W(DW)
    ) u_delay (
        .clk      (CLK),
        .rst      (RST),
        .load     (cnt_load),
        .load_val (cnt_val),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    always_comb begin
        state_d  = state;
        pass_d   = pass;
        grp_d    = GRP;
        ph_d     = PH;
        bank_d   = BANK;
        cnt_load = 1'b0;
        cnt_val  = '0;
        cnt_dec  = 1'b0;

        case (state)
            IDLE: begin
                if (IN_VLD) begin
                    state_d = START;
                    pass_d  = '0;
                    grp_d   = '0;
                    ph_d    = '0;
                end
            end
            START: begin
                if (W_LAT > 0) begin
                    state_d  = ALIGN;
                    cnt_load = 1'b1;
                    cnt_val  = ALIGN_LD;
                end else begin
                    state_d = RUN;
                end
            end
            ALIGN: begin
                if (cnt_zero) state_d = RUN;
                else          cnt_dec = 1'b1;
            end
            RUN: begin
                if (PH == PH_LAST) begin
                    ph_d = '0;
                    if (GRP == GRP_LAST) begin
                        // End of pass: the buffer just written becomes the next read bank.
                        grp_d  = '0;
                        bank_d = ~BANK;
                        if (pass < PASS_LAST) begin
                            pass_d  = pass + 1'b1;
                            state_d = START;
                        end else if (BF_LAT > 0) begin
                            state_d  = DRAIN;
                            cnt_load = 1'b1;
                            cnt_val  = DRAIN_LD;
                        end else begin
                            state_d = DONE;
                        end
                    end else begin
                        grp_d = GRP + 1'b1;
                    end
                end else begin
                    ph_d = PH + 1'b1;
                end
            end
            DRAIN: begin
                if (cnt_zero) state_d = DONE;
                else          cnt_dec = 1'b1;
            end
            DONE: begin
                if (OUT_RDY) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Strobes are registered from the next state so they line up with it exactly.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= IDLE;
            pass      <= '0;
            GRP       <= '0;
            PH        <= '0;
            BANK      <= 1'b0;
            W_START   <= 1'b0;
            W_STAGE   <= 1'b0;
            BF_EN     <= 1'b0;
            PASS_DONE <= 1'b0;
        end else begin
            state     <= state_d;
            pass      <= pass_d;
            GRP       <= grp_d;
            PH        <= ph_d;
            BANK      <= bank_d;
            W_START   <= (state_d == START);
            W_STAGE   <= pass_d[0];
            BF_EN     <= (state_d == RUN);
            PASS_DONE <= (state_d == RUN) && (grp_d == GRP_LAST) && (ph_d == PH_LAST);
        end
    end

    assign IN_RDY  = (state == IDLE);
    assign OUT_VLD = (state == DONE);
    assign BUSY    = (state != IDLE);

endmodule

// File: tb/tb_fft32_stage_ctrl.sv
// Bench for fft32_stage_ctrl: default instance plus a W_LAT=1/BF_LAT=0 instance,
// a frame-schedule reference model, a directed vector table and random traffic.
module tb_fft32_stage_ctrl;

    typedef struct packed {
        logic       in_rdy;
        logic       w_start;
        logic       w_stage;
        logic       bf_en;
        logic [2:0] grp;
        logic [1:0] ph;
        logic       bank;
        logic       pass_done;
        logic       out_vld;
        logic       busy;
    } obs_t;

    typedef struct {
        int         k;
        logic       in_vld;
        logic       out_rdy;
        obs_t       exp0;
        logic [1:0] exp1;
    } vec_t;

    logic clk = 1'b0;
    logic rst, in_vld, out_rdy;

    logic       in_rdy_0, w_start_0, w_stage_0, bf_en_0, bank_0, pass_done_0, out_vld_0, busy_0;
    logic [2:0] grp_0;
    logic [1:0] ph_0;
    logic       in_rdy_1, w_start_1, w_stage_1, bf_en_1, bank_1, pass_done_1, out_vld_1, busy_1;
    logic [2:0] grp_1;
    logic [1:0] ph_1;

    obs_t obs0, obs1;
    assign obs0 = {in_rdy_0, w_start_0, w_stage_0, bf_en_0, grp_0, ph_0, bank_0, pass_done_0, out_vld_0, busy_0};
    assign obs1 = {in_rdy_1, w_start_1, w_stage_1, bf_en_1, grp_1, ph_1, bank_1, pass_done_1, out_vld_1, busy_1};

    fft32_stage_ctrl u_dut (
        .CLK(clk), .RST(rst), .IN_VLD(in_vld), .IN_RDY(in_rdy_0),
        .W_START(w_start_0), .W_STAGE(w_stage_0), .BF_EN(bf_en_0),
        .GRP(grp_0), .PH(ph_0), .BANK(bank_0), .PASS_DONE(pass_done_0),
        .OUT_VLD(out_vld_0), .OUT_RDY(out_rdy), .BUSY(busy_0)
    );

    fft32_stage_ctrl #(.W_LAT(1), .BF_LAT(0)) u_dut1 (
        .CLK(clk), .RST(rst), .IN_VLD(in_vld), .IN_RDY(in_rdy_1),
        .W_START(w_start_1), .W_STAGE(w_stage_1), .BF_EN(bf_en_1),
        .GRP(grp_1), .PH(ph_1), .BANK(bank_1), .PASS_DONE(pass_done_1),
        .OUT_VLD(out_vld_1), .OUT_RDY(out_rdy), .BUSY(busy_1)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    int n_chk = 0;
    int n_fail = 0;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic obs_t mk(input bit ir, input bit ws, input bit wst, input bit bf,
                                input int g, input int p, input bit bk, input bit pd,
                                input bit ov, input bit bz);
        obs_t o;
        o = '{in_rdy: ir, w_start: ws, w_stage: wst, bf_en: bf, grp: 3'(g), ph: 2'(p),
              bank: bk, pass_done: pd, out_vld: ov, busy: bz};
        return o;
    endfunction

    // Expected outputs k cycles after the accepting handshake, from the frame schedule:
    // each pass is START, wl ALIGN cycles, 32 RUN cycles; then bl DRAIN cycles, then DONE.
    function automatic obs_t model_out(input bit active, input int k, input int wl, input int bl,
                                       input bit stage_hold, input bit bank_base);
        obs_t o;
        int pl, p, r, idx;
        o = '0;
        if (!active) begin
            o.in_rdy  = 1'b1;
            o.w_stage = stage_hold;
            o.bank    = bank_base;
            return o;
        end
        o.busy = 1'b1;
        pl = 1 + wl + 32;
        if (k <= 2 * pl) begin
            p = (k - 1) / pl;
            r = (k - 1) % pl;
            o.w_stage = (p % 2 == 1);
            o.bank    = bank_base ^ (p % 2 == 1);
            if (r == 0) begin
                o.w_start = 1'b1;
            end else if (r > wl) begin
                idx = r - 1 - wl;
                o.bf_en     = 1'b1;
                o.grp       = 3'(idx / 4);
                o.ph        = 2'(idx % 4);
                o.pass_done = (idx == 31);
            end
        end else begin
            o.w_stage = 1'b1;
            o.bank    = bank_base;
            o.out_vld = (k >= 2 * pl + bl + 1);
        end
        return o;
    endfunction

    bit m_act[2];
    int m_t[2];
    bit m_sh[2];
    bit m_bb[2];
    int wl_of[2] = '{3, 1};
    int bl_of[2] = '{4, 0};

    initial begin
        for (int i = 0; i < 2; i++) begin
            m_act[i] = 0; m_t[i] = 0; m_sh[i] = 0; m_bb[i] = 0;
        end
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                obs_t e, a;
                a = (i == 0) ? obs0 : obs1;
                if (rst) begin
                    e = model_out(1'b0, 0, wl_of[i], bl_of[i], 1'b0, 1'b0);
                    m_act[i] = 0; m_sh[i] = 0; m_bb[i] = 0;
                end else begin
                    e = model_out(m_act[i], cyc - m_t[i], wl_of[i], bl_of[i], m_sh[i], m_bb[i]);
                    if (m_act[i] && e.out_vld && out_rdy) begin
                        m_act[i] = 0;
                        m_sh[i]  = 1;
                    end else if (!m_act[i] && in_vld) begin
                        m_act[i] = 1;
                        m_t[i]   = cyc;
                    end
                end
                check((i == 0) ? "model_dflt" : "model_wlat1", 32'(a), 32'(e));
            end
        end
    end

    vec_t vecs[$];
    obs_t rst_obs;
    obs_t o_align, o_drain, o_done;
    int t0, c1, c2, guard;
    bit found;

    initial begin
        rst_obs = mk(1,0,0,0,0,0,0,0,0,0);
        o_align = mk(0,0,0,0,0,0,0,0,0,1);
        o_drain = mk(0,0,1,0,0,0,0,0,0,1);
        o_done  = mk(0,0,1,0,0,0,0,0,1,1);
        vecs.push_back('{0,  1'b1, 1'b0, rst_obs,                     2'b00});
        vecs.push_back('{1,  1'b0, 1'b0, mk(0,1,0,0,0,0,0,0,0,1),     2'b00});
        vecs.push_back('{2,  1'b0, 1'b0, o_align,                     2'b00});
        vecs.push_back('{3,  1'b0, 1'b0, o_align,                     2'b10});
        vecs.push_back('{5,  1'b0, 1'b0, mk(0,0,0,1,0,0,0,0,0,1),     2'b10});
        vecs.push_back('{10, 1'b0, 1'b0, mk(0,0,0,1,1,1,0,0,0,1),     2'b10});
        vecs.push_back('{20, 1'b1, 1'b0, mk(0,0,0,1,3,3,0,0,0,1),     2'b10});
        vecs.push_back('{21, 1'b0, 1'b0, mk(0,0,0,1,4,0,0,0,0,1),     2'b10});
        vecs.push_back('{36, 1'b0, 1'b0, mk(0,0,0,1,7,3,0,1,0,1),     2'b00});
        vecs.push_back('{37, 1'b0, 1'b0, mk(0,1,1,0,0,0,1,0,0,1),     2'b10});
        vecs.push_back('{41, 1'b0, 1'b0, mk(0,0,1,1,0,0,1,0,0,1),     2'b10});
        vecs.push_back('{68, 1'b0, 1'b0, mk(0,0,1,1,6,3,1,0,0,1),     2'b10});
        vecs.push_back('{69, 1'b0, 1'b0, mk(0,0,1,1,7,0,1,0,0,1),     2'b01});
        vecs.push_back('{72, 1'b0, 1'b0, mk(0,0,1,1,7,3,1,1,0,1),     2'b01});
        vecs.push_back('{73, 1'b0, 1'b0, o_drain,                     2'b01});
        vecs.push_back('{76, 1'b0, 1'b0, o_drain,                     2'b01});
        vecs.push_back('{77, 1'b0, 1'b0, o_done,                      2'b01});
        vecs.push_back('{80, 1'b1, 1'b0, o_done,                      2'b01});
        vecs.push_back('{87, 1'b0, 1'b1, o_done,                      2'b01});
        vecs.push_back('{88, 1'b0, 1'b0, mk(1,0,1,0,0,0,0,0,0,0),     2'b00});

        rst = 1'b1; in_vld = 1'b0; out_rdy = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_dflt", 32'(obs0), 32'(rst_obs));
        check("reset_wlat1", 32'(obs1), 32'(rst_obs));
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk); #1;

        // Directed frame: vector k is the cycle offset from the handshake.
        t0 = cyc;
        for (int i = 0; i < vecs.size(); i++) begin
            while (cyc < t0 + vecs[i].k) begin
                @(posedge clk); #1;
            end
            in_vld  = vecs[i].in_vld;
            out_rdy = vecs[i].out_rdy;
            @(negedge clk);
            check($sformatf("vec_dflt_k%0d", vecs[i].k), 32'(obs0), 32'(vecs[i].exp0));
            check($sformatf("vec_wlat1_k%0d", vecs[i].k), 32'({bf_en_1, out_vld_1}), 32'(vecs[i].exp1));
        end

        // Back-to-back frames: frame-start W_START pulses (stage 0) 78 cycles apart.
        @(posedge clk); #1 in_vld = 1'b1; out_rdy = 1'b1;
        c1 = -1; c2 = -1; guard = 0;
        while (c2 < 0 && guard < 300) begin
            @(negedge clk);
            guard++;
            if (w_start_0 && !w_stage_0) begin
                if (c1 < 0) c1 = cyc;
                else        c2 = cyc;
            end
        end
        check("b2b_found", 32'(c2 >= 0), 32'(1));
        check("b2b_spacing", 32'(c2 - c1), 32'(78));

        // Reset in the middle of pass 1 at GRP 5.
        found = 0; guard = 0;
        while (!found && guard < 200) begin
            @(negedge clk);
            guard++;
            found = bf_en_0 && w_stage_0 && (grp_0 == 3'd5);
        end
        check("midpass_found", 32'(found), 32'(1));
        @(posedge clk); #2 rst = 1'b1;
        #1 check("rst_async", 32'(obs0), 32'(rst_obs));
        @(posedge clk); #1 rst = 1'b0;
        found = 0; guard = 0;
        while (!found && guard < 20) begin
            @(negedge clk);
            guard++;
            found = w_start_0;
        end
        check("post_rst_start", 32'(found), 32'(1));
        check("post_rst_stage_bank", 32'({w_stage_0, bank_0}), 32'(0));

        // Random traffic with occasional resets, checked by the schedule model.
        for (int n = 0; n < 3000; n++) begin
            @(posedge clk); #1;
            in_vld  = ($urandom_range(0, 3) == 0);
            out_rdy = ($urandom_range(0, 2) == 0);
            rst     = ($urandom_range(0, 999) == 0);
        end
        @(posedge clk); #1 rst = 1'b0; in_vld = 1'b0; out_rdy = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk); #1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/fft32_stage_ctrl.md
# fft32_stage_ctrl

Frame sequencer for the 32-point pipelined FFT. It accepts one frame-start handshake and drives the twiddle ROM's `START`/`STAGE` inputs. It then steps the butterfly datapath through two passes of 8 groups × 4 cycles and swaps ping-pong buffer banks between passes. It signals frame completion to the downstream consumer with a valid/ready handshake.

## Interface
Parameters:
- `NGRP`, 8: twiddle groups per pass (32 points / 4 lanes).
- `GCYC`, 4: cycles each twiddle word is held per group.
- `NPASS`, 2: passes per frame. Pass index drives `W_STAGE`.
- `W_LAT`, 3: cycles from the `W_START` pulse to the first valid twiddle word (group 0).
- `BF_LAT`, 4: butterfly pipeline depth, drained after the last pass.

Ports:
- `CLK` in 1: single clock, rising edge.
- `RST` in 1: reset, asynchronous, active-high.
- `IN_VLD` in 1: frame loaded in bank 0, request to start.
- `IN_RDY` out 1: controller idle. A frame is accepted when `IN_VLD & IN_RDY`.
- `W_START` out 1: one-cycle pulse to the twiddle ROM `START`.
- `W_STAGE` out 1: twiddle ROM stage select (= current pass).
- `BF_EN` out 1: butterfly enable. High while group data and twiddles are aligned.
- `GRP` out 3: current group index 0..7.
- `PH` out 2: cycle phase within group 0..3.
- `BANK` out 1: read bank for the current pass. The write bank is `~BANK`.
- `PASS_DONE` out 1: one-cycle pulse on the last `RUN` cycle of each pass.
- `OUT_VLD` out 1: result frame available in bank `BANK`.
- `OUT_RDY` in 1: downstream accepts the result.
- `BUSY` out 1: high in every state except `IDLE`.

## Operation
States:
- `IDLE`: `IN_RDY`=1. On `IN_VLD`, clear `PASS`, `GRP`, `PH`; go to `START`.
- `START`: one cycle. `W_START`=1, `W_STAGE`=`PASS`. Go to `ALIGN`.
- `ALIGN`: hold for `W_LAT` cycles (counter `W_LAT-1`..0), then go to `RUN`.
- `RUN`: `BF_EN`=1. `PH` increments every cycle. When `PH`=3, `GRP` increments. At `GRP`=7 and `PH`=3:
  - pulse `PASS_DONE`, toggle `BANK`, clear `GRP` and `PH`;
  - if `PASS`<`NPASS-1`: `PASS`++ and go to `START`;
  - otherwise go to `DRAIN`.
- `DRAIN`: `BF_EN`=0. Hold for `BF_LAT` cycles, then go to `DONE`.
- `DONE`: `OUT_VLD`=1 until `OUT_RDY` is high. On the `OUT_VLD & OUT_RDY` cycle go to `IDLE`.

Rules:
- `IN_VLD` is ignored outside `IDLE`. `OUT_RDY` is ignored outside `DONE`.
- `OUT_VLD` must not drop before it is accepted.
- Counter widths: `GRP` is `$clog2(NGRP)`, `PH` is `$clog2(GCYC)`, the shared delay counter is `$clog2(max(W_LAT,BF_LAT)+1)`.
- `GRP` and `PH` wrap only through the explicit clear; they never overflow silently.

## Timing
- All outputs are registered except `IN_RDY`, `OUT_VLD` and `BUSY`, which are decoded from state.
- Reset values: state `IDLE`, `W_START`=0, `W_STAGE`=0, `BF_EN`=0, `GRP`=0, `PH`=0, `BANK`=0, `PASS_DONE`=0. Hence `IN_RDY`=1, `OUT_VLD`=0, `BUSY`=0.
- `RST` asserted in any state returns to these values on the next evaluation, with no pending pulse. The ROM is restarted by the next `W_START`.
- The handshake cycle is T. Then:
  - `W_START` is high at T+1;
  - `BF_EN` first rises at T+2+`W_LAT`;
  - each pass is 1+`W_LAT`+32 cycles;
  - `OUT_VLD` rises at T+1+`NPASS`·(1+`W_LAT`+32)+`BF_LAT`.
- With default parameters, `OUT_VLD` rises at T+77.
- Minimum frame-to-frame spacing with `OUT_RDY` tied high is 78 cycles.
- `W_STAGE` is stable from the `START` cycle through the end of that pass's `RUN`.

## Structure
- Shared package `fft32_pkg`:
  - state enum (`IDLE`, `START`, `ALIGN`, `RUN`, `DRAIN`, `DONE`);
  - constants `FFT_N`=32, `FFT_LANES`=4, twiddle width 9;
  - derived `NGRP`.
- One natural sub-module: `fft32_delay_cnt`, a loadable down-counter with a zero flag, used by both `ALIGN` and `DRAIN`.
- Everything else is flat in this block.

## Test plan
- Reset release, then `IN_VLD` held high at T: `W_START` at T+1 with `W_STAGE`=0. `BF_EN` high T+5..T+36 with `GRP` 0..7 and `PH` 0..3 repeating. `PASS_DONE` at T+36. `W_START` at T+37 with `W_STAGE`=1. `OUT_VLD` at T+77.
- Back-to-back with `OUT_RDY`=1 and `IN_VLD` held high: second `W_START` exactly 78 cycles after the first. `BANK` sequence per frame is 0, 1, then 0.
- `OUT_RDY` low for 10 cycles in `DONE`: `OUT_VLD` stays high and `IN_RDY` stays 0. A new `IN_VLD` during this time is not accepted. Return to `IDLE` on the first `OUT_RDY`.
- `RST` asserted mid-pass 1 (`GRP`=5): all outputs take their reset values at once. A new frame afterwards starts with `W_STAGE`=0 and `BANK`=0.
- `IN_VLD` pulsed during `RUN`: no effect on `GRP`, `PH` or `PASS`, and no extra `W_START`.
- Parameter override `W_LAT`=1, `BF_LAT`=0: `BF_EN` rises at T+3 and `OUT_VLD` rises at T+69.
